// File: rtl/data_mem_resp.sv
// Data-memory responder with a fixed, parameterised access latency.
// Word-addressed 16-bit array; read data is registered.
module data_mem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] a_q;
  logic [15:0] d_q;
  logic        wr_q;

  logic [15:0] mem [DEPTH];

  logic                  oor;
  logic                  fire;
  logic [DEPTH_LOG2-1:0] idx;

  assign oor  = (a_q >> DEPTH_LOG2) != 16'd0;
  assign fire = (state == BUSY) && (cnt == 4'd0);
  assign idx  = a_q[DEPTH_LOG2-1:0];

  // Gated by reset so a requester still holding its
  // request sees no freeze while the block is in reset.
  assign stall = rst_n &&
    (((state == IDLE) && (re ^ we)) || (state == BUSY));

  always_ff @(posedge clk) begin
    if (fire && wr_q && !oor)
      mem[idx] <= d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      a_q     <= 16'd0;
      d_q     <= 16'd0;
      wr_q    <= 1'b0;
      rd_data <= 16'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (re ^ we) begin
            a_q   <= addr;
            d_q   <= wrt_data;
            wr_q  <= we;
            cnt   <= 4'(LATENCY - 1);
            state <= BUSY;
          end else if (re && we) begin
            err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!wr_q)
              rd_data <= oor ? 16'd0 : mem[idx];
            done  <= 1'b1;
            err   <= oor;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
